cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
- Cache controller stage between the CPU bus and the 128-byte direct-mapped cache, with main memory behind it.
- Accepts CPU byte reads and writes, drives the cache lookup, and handles a read miss by fetching from main memory and filling the cache line.
- Writes are write-through and write-allocate: the cache is updated and memory is written.
- Single in-flight request; all outputs are registered.

Parameters:
- ADDR_W, 16, CPU/memory address width
- DATA_W, 8, data width
- INDEX_W, 7, cache index bits (address[6:0]); tag = address[ADDR_W-1:INDEX_W]

Ports:
- clk_1  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  request strobe, sampled only in IDLE
- cpu_we  in  1  1=write, 0=read; captured with cpu_req
- cpu_addr  in  ADDR_W  request address; captured with cpu_req
- cpu_wdata  in  DATA_W  write data; captured with cpu_req
- cpu_rdata  out  DATA_W  read result; valid when cpu_ready=1, held until the next read completes
- cpu_ready  out  1  one-cycle completion pulse
- c_w_en  out  1  cache write enable (cache w_en)
- c_addr  out  ADDR_W  cache address
- c_wdata  out  DATA_W  data driven onto the cache data bus when c_w_en=1 (the top level owns the tristate)
- c_rdata  in  DATA_W  cache data bus read value
- c_hit  in  1  cache hit flag
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write select
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, single cycle

Behaviour:
- Reset (rst=1 at the clk_1 edge):
  - State goes to IDLE.
  - cpu_ready=0, cpu_rdata=0, c_w_en=0, c_addr=0, c_wdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-transaction abandons it: mem_req drops on that edge and no cpu_ready is issued.
- IDLE: on cpu_req=1, register addr, we and wdata. Read goes to LOOKUP; write goes to WR_CACHE. cpu_req is ignored in every other state.
- LOOKUP (1 cycle):
  - c_addr=addr, c_w_en=0. The cache responds combinationally; c_hit and c_rdata are sampled at the end of the cycle.
  - If c_hit==1: cpu_rdata<=c_rdata, go to DONE. Any other value of c_hit counts as a miss.
  - On a miss: go to MEM_RD.
- MEM_RD: mem_req=1, mem_we=0, mem_addr=addr. On mem_ack: fill<=mem_rdata, cpu_rdata<=mem_rdata, go to FILL.
- FILL (1 cycle): c_w_en=1, c_addr=addr, c_wdata=fill. The cache updates the data byte and the tag. Go to DONE.
- WR_CACHE (1 cycle): c_w_en=1, c_addr=addr, c_wdata=wdata. Go to MEM_WR.
- MEM_WR: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata. On mem_ack go to DONE.
- DONE (1 cycle): cpu_ready=1, then IDLE. A new cpu_req is accepted in the following IDLE cycle at the earliest.
- Latency, counted from the edge that samples cpu_req to the cycle cpu_ready is high:
  - Read hit: 2 cycles.
  - Read miss: 4 + W cycles, where W = wait cycles before mem_ack.
  - Write: 3 + W cycles.
- c_w_en is never high outside FILL and WR_CACHE.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- mem_ack in the first cycle of MEM_RD/MEM_WR is legal (W=0).
- cpu_rdata is unchanged by writes.

Optional Feature:
- Macro CACHE_CTRL_STATS_EN.
- When defined, adds two outputs:
  - hit_cnt[15:0]: increments on each LOOKUP hit.
  - miss_cnt[15:0]: increments on each LOOKUP miss.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and the logic are absent. Core timing is identical either way.

Decomposition:
- Package cache_pkg holds:
  - ADDR_W, DATA_W, INDEX_W, TAG_W constants.
  - State enum: IDLE, LOOKUP, MEM_RD, FILL, WR_CACHE, MEM_WR, DONE.
- Optional sub-module cache_stats holds the saturating counters and is instantiated only under CACHE_CTRL_STATS_EN.
- The FSM stays in cache_ctrl.

Test Plan:
- Reset, then read 16'h0085 with the cache pre-tagged to return c_hit=1, c_rdata=8'h5A -> cpu_ready 2 cycles after request, cpu_rdata=8'h5A, mem_req never asserted.
- Read 16'h1234 with c_hit=0; memory acks after 3 waits with 8'hC3 -> mem_req held for 4 cycles; FILL drives c_w_en=1, c_addr=16'h1234, c_wdata=8'hC3; cpu_ready at cycle 7; cpu_rdata=8'hC3.
- Write 16'h00FF=8'hA7 with immediate ack -> WR_CACHE pulses c_w_en with c_wdata=8'hA7; mem_we=1, mem_wdata=8'hA7; cpu_ready at cycle 3; a following read of 16'h00FF hits in 2 cycles.
- rst asserted during MEM_RD wait -> mem_req=0 next edge, no cpu_ready; a late mem_ack in IDLE is ignored; the next read completes normally.
- cpu_req held high continuously and stray mem_ack pulses in IDLE/LOOKUP -> exactly one transaction per IDLE acceptance; no spurious cpu_ready or c_w_en.
- With CACHE_CTRL_STATS_EN: 3 hits + 2 misses -> hit_cnt=3, miss_cnt=2; preload near saturation -> counters stay at 16'hFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and FSM state encoding for the cache controller slice.
package cache_pkg;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int INDEX_W = 7;
  localparam int TAG_W   = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, FILL, WR_CACHE, MEM_WR, DONE
  } state_e;
endpackage

// File: rtl/cache_stats.sv
// Saturating hit/miss counters; instantiated only when CACHE_CTRL_STATS_EN is defined.
module cache_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        hit_inc,
  input  logic        miss_inc,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    if (inc && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  always_comb begin
    hit_cnt_d  = sat_inc(hit_cnt_q, hit_inc);
    miss_cnt_d = sat_inc(miss_cnt_q, miss_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: read-miss fill, write-through/write-allocate.
// Optional hit/miss counters are enabled by defining CACHE_CTRL_STATS_EN.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic              clk_1,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              c_w_en,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_wdata,
  input  logic [DATA_W-1:0] c_rdata,
  input  logic              c_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              c_w_en_q, c_w_en_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  // Outputs are computed for the state being entered, so they are valid throughout it.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    c_addr_d    = c_addr_q;
    c_wdata_d   = c_wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_d = 1'b0;
    c_w_en_d    = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    case (state_q)
      IDLE: if (cpu_req) begin
        addr_d   = cpu_addr;
        wdata_d  = cpu_wdata;
        c_addr_d = cpu_addr;
        if (cpu_we) begin
          state_d   = WR_CACHE;
          c_w_en_d  = 1'b1;
          c_wdata_d = cpu_wdata;
        end else begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: if (c_hit == 1'b1) begin
        cpu_rdata_d = c_rdata;
        cpu_ready_d = 1'b1;
        state_d     = DONE;
      end else begin
        mem_req_d  = 1'b1;
        mem_addr_d = addr_q;
        state_d    = MEM_RD;
      end
      MEM_RD: begin
        mem_req_d = 1'b1;
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          cpu_rdata_d = mem_rdata;
          c_wdata_d   = mem_rdata;
          c_addr_d    = addr_q;
          c_w_en_d    = 1'b1;
          state_d     = FILL;
        end
      end
      FILL: begin
        cpu_ready_d = 1'b1;
        state_d     = DONE;
      end
      WR_CACHE: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = wdata_q;
        state_d     = MEM_WR;
      end
      MEM_WR: begin
        mem_req_d = 1'b1;
        mem_we_d  = 1'b1;
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          cpu_ready_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state_q     <= IDLE;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      c_w_en_q    <= 1'b0;
      c_addr_q    <= '0;
      c_wdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      c_w_en_q    <= c_w_en_d;
      c_addr_q    <= c_addr_d;
      c_wdata_q   <= c_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Request payload registers carry no control meaning and need no reset.
  always_ff @(posedge clk_1) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign c_w_en    = c_w_en_q;
  assign c_addr    = c_addr_q;
  assign c_wdata   = c_wdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef CACHE_CTRL_STATS_EN
  logic lookup_hit, lookup_miss;
  assign lookup_hit  = (state_q == LOOKUP) && (c_hit == 1'b1);
  assign lookup_miss = (state_q == LOOKUP) && !(c_hit == 1'b1);

  cache_stats u_stats (
    .clk      (clk_1),
    .rst      (rst),
    .hit_inc  (lookup_hit),
    .miss_inc (lookup_miss),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl: acts as cache array and memory,
// and predicts latency, fills and read data from a line-tag/memory-image model.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic clk_1 = 1'b0;
  always #5 clk_1 = ~clk_1;

  logic              rst, cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr, c_addr, mem_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata, c_wdata, c_rdata, mem_wdata, mem_rdata;
  logic              cpu_ready, c_w_en, c_hit, mem_req, mem_we, mem_ack;
`ifdef CACHE_CTRL_STATS_EN
  logic [15:0]       hit_cnt, miss_cnt;
`endif

  cache_ctrl dut (
    .clk_1(clk_1), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .c_w_en(c_w_en), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_hit(c_hit), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Environment cache array, written only by the DUT's c_w_en
  logic [TAG_W-1:0]  ec_tag  [128];
  logic              ec_val  [128];
  logic [DATA_W-1:0] ec_data [128];

  always_comb begin
    c_hit   = ec_val[c_addr[INDEX_W-1:0]] && (ec_tag[c_addr[INDEX_W-1:0]] == c_addr[ADDR_W-1:INDEX_W]);
    c_rdata = ec_data[c_addr[INDEX_W-1:0]];
  end

  logic [DATA_W-1:0] env_mem [int];
  logic [DATA_W-1:0] ref_mem [int];
  logic [TAG_W-1:0]  ref_tag [128];
  logic              ref_val [128];
  logic [DATA_W-1:0] ref_rdata;
  int                ref_hits, ref_misses;
  int                n_chk, n_pass;

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] env_rd(input logic [15:0] a);
    if (env_mem.exists(int'(a))) return env_mem[int'(a)];
    return init_val(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    rst = 1'b0;
    ref_rdata  = '0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic run_txn(input bit we, input logic [15:0] a, input logic [7:0] d,
                         input int w, input bit hold, input bit stray);
    logic [TAG_W-1:0] t;
    logic [6:0]       idx;
    bit               exp_hit, done;
    int               exp_lat, k, lat, memcyc, wen;
    logic [7:0]       exp_data, rd_seen;
    t        = a[15:7];
    idx      = a[6:0];
    exp_hit  = !we && ref_val[idx] && (ref_tag[idx] == t);
    exp_lat  = we ? 3 + w : (exp_hit ? 2 : 4 + w);
    exp_data = we ? d : ref_rd(a);
    k = 0; lat = 0; memcyc = 0; wen = 0; done = 0; rd_seen = '0;
    @(negedge clk_1);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    @(posedge clk_1);
    while (!done && k < 60) begin
      @(negedge clk_1);
      mem_ack = 1'b0;
      if (hold) begin
        cpu_addr  = 16'($urandom);
        cpu_we    = 1'($urandom);
        cpu_wdata = 8'($urandom);
      end else begin
        cpu_req = 1'b0;
      end
      if (c_w_en) begin
        wen++;
        if (wen == 1) begin
          chk("c_addr", 32'(c_addr), 32'(a));
          chk("c_wdata", 32'(c_wdata), 32'(exp_data));
        end
        ec_val[c_addr[6:0]]  = 1'b1;
        ec_tag[c_addr[6:0]]  = c_addr[15:7];
        ec_data[c_addr[6:0]] = c_wdata;
      end
      if (mem_req) begin
        memcyc++;
        if (memcyc == w + 1) begin
          mem_ack = 1'b1;
          chk("mem_addr", 32'(mem_addr), 32'(a));
          chk("mem_we", 32'(mem_we), 32'(we));
          if (mem_we) begin
            chk("mem_wdata", 32'(mem_wdata), 32'(d));
            env_mem[int'(mem_addr)] = mem_wdata;
          end else begin
            mem_rdata = env_rd(mem_addr);
          end
        end
      end else if (stray) begin
        mem_ack   = 1'($urandom);
        mem_rdata = 8'($urandom);
      end
      if (cpu_ready) begin
        lat     = k + 1;
        rd_seen = cpu_rdata;
        done    = 1;
        cpu_req = 1'b0;
      end
      k++;
    end
    if (!done) chk("timeout", 32'd0, 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("c_w_en_pulses", 32'(wen), (we || !exp_hit) ? 32'd1 : 32'd0);
    chk("mem_req_cycles", 32'(memcyc), exp_hit ? 32'd0 : 32'(w + 1));
    chk("cpu_rdata", 32'(rd_seen), we ? 32'(ref_rdata) : 32'(exp_data));
    @(negedge clk_1);
    mem_ack = 1'b0;
    chk("ready_single", 32'(cpu_ready), 32'd0);
    chk("c_w_en_idle", 32'(c_w_en), 32'd0);
    ref_val[idx] = 1'b1;
    ref_tag[idx] = t;
    if (we) ref_mem[int'(a)] = d;
    else begin
      ref_rdata = exp_data;
      if (exp_hit) ref_hits++; else ref_misses++;
    end
  endtask

  initial begin
    bit bad;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 128; i++) begin
      ec_val[i] = 1'b0; ec_tag[i] = '0; ec_data[i] = '0;
      ref_val[i] = 1'b0; ref_tag[i] = '0;
    end
    do_reset();
    chk("rst_ready", 32'(cpu_ready), 32'd0);
    chk("rst_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_c_w_en", 32'(c_w_en), 32'd0);
    chk("rst_c_addr", 32'(c_addr), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);

    // Pre-tagged hit line
    ec_val[7'h05] = 1'b1; ec_tag[7'h05] = 9'd1; ec_data[7'h05] = 8'h5A;
    ref_val[7'h05] = 1'b1; ref_tag[7'h05] = 9'd1;
    env_mem[int'(16'h0085)] = 8'h5A; ref_mem[int'(16'h0085)] = 8'h5A;
    run_txn(1'b0, 16'h0085, 8'h00, 0, 1'b0, 1'b0);

    env_mem[int'(16'h1234)] = 8'hC3; ref_mem[int'(16'h1234)] = 8'hC3;
    run_txn(1'b0, 16'h1234, 8'h00, 3, 1'b0, 1'b0);
    run_txn(1'b1, 16'h00FF, 8'hA7, 0, 1'b0, 1'b0);
    run_txn(1'b0, 16'h00FF, 8'h00, 0, 1'b0, 1'b0);

    // Reset while waiting on memory, then a late ack in IDLE
    @(negedge clk_1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h2345;
    @(negedge clk_1);
    cpu_req = 1'b0;
    @(negedge clk_1);
    chk("mem_req_pre_rst", 32'(mem_req), 32'd1);
    @(negedge clk_1);
    rst = 1'b1;
    @(negedge clk_1);
    rst = 1'b0;
    ref_rdata = '0; ref_hits = 0; ref_misses = 0;
    chk("mem_req_rst", 32'(mem_req), 32'd0);
    chk("ready_rst", 32'(cpu_ready), 32'd0);
    mem_ack = 1'b1; mem_rdata = 8'hEE;
    @(negedge clk_1);
    mem_ack = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cpu_ready || mem_req || c_w_en) bad = 1'b1;
      @(negedge clk_1);
    end
    chk("late_ack_ignored", 32'(bad), 32'd0);
    run_txn(1'b0, 16'h2345, 8'h00, 1, 1'b0, 1'b0);

    // cpu_req held high with stray acks
    for (int i = 0; i < 6; i++)
      run_txn(1'(i % 2), {7'd0, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 15))},
              8'($urandom), $urandom_range(0, 3), 1'b1, 1'b1);

    for (int i = 0; i < 40; i++)
      run_txn(1'($urandom), {7'd0, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 15))},
              8'($urandom), $urandom_range(0, 4), 1'($urandom), 1'($urandom));

`ifdef CACHE_CTRL_STATS_EN
    chk("hit_cnt", 32'(hit_cnt), 32'(ref_hits));
    chk("miss_cnt", 32'(miss_cnt), 32'(ref_misses));
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
